prm_edge_chk_sched: RTL and testbench

- Sequencer for the PRM obstacle-check datapath.
- On a start command it walks a contiguous range of roadmap edges:
  - fetches each edge's 15-bit joint-cell code from the edge table;
  - drives the code onto the shared combinational obstacle-checker bank (inputs A..O, one edge_mask bit per obstacle checker);
  - samples the per-obstacle masks and streams one blocked/free verdict per edge to the roadmap builder over a valid/ready handshake.
- Sits between the edge-table ROM, the checker bank and the graph-update logic.

---
 rtl/prm_edge_chk_sched.sv | 137 +++++++++++++
 tb/tb_prm_edge_chk_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_chk_sched.sv
// Sequences edge-table fetches into the combinational obstacle-checker bank and streams per-edge verdicts.
// Latency: per edge, fetch latency + CHK_LAT + 2 cycles (chk_mask sampled CHK_LAT+1 cycles after chk_code changes).
// Backpressure: res_vld holds index/mask stable until res_rdy; no new fetch issues until the result is taken.
// Optional: define PRM_EDGE_CHK_STATS_EN to add the saturating blocked_cnt output.
module prm_edge_chk_sched #(
    parameter int CODE_W  = 15,
    parameter int IDX_W   = 10,
    parameter int NUM_OBS = 8,
    parameter int CHK_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [IDX_W-1:0]   base_idx,
    input  logic [IDX_W-1:0]   edge_cnt,
    output logic               busy,
    output logic               done,
    output logic               code_req,
    output logic [IDX_W-1:0]   code_addr,
    input  logic               code_vld,
    input  logic [CODE_W-1:0]  code_data,
    output logic [CODE_W-1:0]  chk_code,
    input  logic [NUM_OBS-1:0] chk_mask,
    output logic               res_vld,
    input  logic               res_rdy,
    output logic [IDX_W-1:0]   res_idx,
    output logic               res_blocked,
    output logic [NUM_OBS-1:0] res_obs
`ifdef PRM_EDGE_CHK_STATS_EN
    ,
    output logic [IDX_W:0]     blocked_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rem;
    logic [2:0]       wait_cnt;
    logic             start_acc;
    logic             res_xfer;

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FIN);
    assign code_req    = (state == S_FETCH);
    assign res_vld     = (state == S_EMIT);
    assign code_addr   = idx;
    assign res_blocked = |res_obs;

    // abort wins over start when both arrive in IDLE
    assign start_acc = (state == S_IDLE) && start && !abort;
    assign res_xfer  = res_vld && res_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            rem      <= '0;
            wait_cnt <= '0;
            chk_code <= '0;
            res_idx  <= '0;
            res_obs  <= '0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_acc) begin
                        if (edge_cnt == '0) begin
                            state <= S_FIN;
                        end else begin
                            idx   <= base_idx;
                            rem   <= edge_cnt;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (code_vld) begin
                        chk_code <= code_data;
                        wait_cnt <= 3'(CHK_LAT);
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // counter runs CHK_LAT..0, so sampling lands CHK_LAT+1 edges after chk_code changed
                    if (wait_cnt == '0) begin
                        res_obs <= chk_mask;
                        res_idx <= idx;
                        state   <= S_EMIT;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_EMIT: begin
                    if (res_rdy) begin
                        idx <= idx + IDX_W'(1);
                        rem <= rem - IDX_W'(1);
                        if (rem == IDX_W'(1)) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PRM_EDGE_CHK_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blocked_cnt <= '0;
        end else if (start_acc) begin
            blocked_cnt <= '0;
        end else if (res_xfer && res_blocked && !(&blocked_cnt)) begin
            blocked_cnt <= blocked_cnt + (IDX_W + 1)'(1);
        end
    end
`else
    logic unused_xfer;
    assign unused_xfer = res_xfer;
`endif

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Directed bench for prm_edge_chk_sched: edge-table responder, delayed checker-bank model, transfer monitor.
module tb_prm_edge_chk_sched;

    localparam int CODE_W  = 15;
    localparam int IDX_W   = 10;
    localparam int NUM_OBS = 8;
    localparam int CHK_LAT = 3;

    logic               clk = 0;
    logic               rst_n = 0;
    logic               start = 0;
    logic               abort = 0;
    logic [IDX_W-1:0]   base_idx = '0;
    logic [IDX_W-1:0]   edge_cnt = '0;
    logic               busy;
    logic               done;
    logic               code_req;
    logic [IDX_W-1:0]   code_addr;
    logic               code_vld = 0;
    logic [CODE_W-1:0]  code_data = '0;
    logic [CODE_W-1:0]  chk_code;
    logic [NUM_OBS-1:0] chk_mask = '0;
    logic               res_vld;
    logic               res_rdy = 0;
    logic [IDX_W-1:0]   res_idx;
    logic               res_blocked;
    logic [NUM_OBS-1:0] res_obs;
`ifdef PRM_EDGE_CHK_STATS_EN
    logic [IDX_W:0]     blocked_cnt;
`endif

    prm_edge_chk_sched #(
        .CODE_W(CODE_W), .IDX_W(IDX_W), .NUM_OBS(NUM_OBS), .CHK_LAT(CHK_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_idx(base_idx), .edge_cnt(edge_cnt), .busy(busy), .done(done),
        .code_req(code_req), .code_addr(code_addr), .code_vld(code_vld),
        .code_data(code_data), .chk_code(chk_code), .chk_mask(chk_mask),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_idx(res_idx),
        .res_blocked(res_blocked), .res_obs(res_obs)
`ifdef PRM_EDGE_CHK_STATS_EN
        , .blocked_cnt(blocked_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CODE_W-1:0] code_of(input logic [IDX_W-1:0] a);
        return {5'b10101, a};
    endfunction

    // Edge-table responder: code_vld on the second cycle of each request
    logic force_vld = 0;
    int   age = 0;
    always @(negedge clk) begin
        if (code_vld) begin
            code_vld = 0;
            age = 0;
        end else if (force_vld) begin
            code_vld = 1;
            code_data = 15'h7fff;
        end else if (code_req) begin
            age++;
            if (age >= 2) begin
                code_vld = 1;
                code_data = code_of(code_addr);
            end
        end else begin
            age = 0;
        end
    end

    // Checker bank: garbage until CHK_LAT cycles after chk_code changes
    logic [7:0]        obs_tab [1024];
    logic              toggle_mask = 0;
    logic [CODE_W-1:0] last_code = '0;
    int                m_age = 100;
    always @(negedge clk) begin
        if (chk_code != last_code) begin
            last_code = chk_code;
            m_age = 0;
        end else if (m_age < 100) begin
            m_age++;
        end
        if (toggle_mask) chk_mask = 8'($urandom);
        else if (m_age >= CHK_LAT) chk_mask = obs_tab[chk_code[9:0]];
        else chk_mask = 8'hA5;
    end

    // Monitor
    int cyc_n = 0, done_n = 0, done_cyc = 0, busy_n = 0, req_n = 0, vld_n = 0;
    int xfer_idx[$], xfer_obs[$], xfer_blk[$], xfer_cyc[$], req_addr[$], req_cyc[$];
    logic prev_req = 0;
    always @(negedge clk) begin
        cyc_n++;
        if (res_vld && res_rdy) begin
            xfer_idx.push_back(int'(res_idx));
            xfer_obs.push_back(int'(res_obs));
            xfer_blk.push_back(int'(res_blocked));
            xfer_cyc.push_back(cyc_n);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc_n;
        end
        if (busy) busy_n++;
        if (code_req) req_n++;
        if (res_vld) vld_n++;
        if (code_req && !prev_req) begin
            req_addr.push_back(int'(code_addr));
            req_cyc.push_back(cyc_n);
        end
        prev_req = code_req;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input int b, input int c);
        base_idx = IDX_W'(b);
        edge_cnt = IDX_W'(c);
        start = 1;
        cyc(1);
        start = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 400), 1);
        @(posedge clk);
        #1;
    endtask

    int x0, r0, d0, b0, q0, v0, n;
    logic [IDX_W-1:0]   i0;
    logic [NUM_OBS-1:0] o0;
    logic [CODE_W-1:0]  cc;
    logic               moved;

    initial begin
        for (int i = 0; i < 1024; i++) obs_tab[i] = 8'h00;
        obs_tab[6]   = 8'h10;
        obs_tab[20]  = 8'h81;
        obs_tab[21]  = 8'h02;
        obs_tab[100] = 8'h40;
        obs_tab[101] = 8'h07;

        cyc(3);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_req", 32'(code_req), 0);
        chk("rst_vld", 32'(res_vld), 0);
        chk("rst_outs", 32'({chk_code, res_idx, res_obs, code_addr} != '0), 0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc(2);

        // basic sweep 5..7
        res_rdy = 1;
        x0 = xfer_idx.size(); d0 = done_n;
        go(5, 3);
        wait_done("t1_timeout");
        cyc(3);
        chk("t1_count", 32'(xfer_idx.size() - x0), 3);
        chk("t1_idx0", 32'(xfer_idx[x0]), 5);
        chk("t1_blk0", 32'(xfer_blk[x0]), 0);
        chk("t1_idx1", 32'(xfer_idx[x0+1]), 6);
        chk("t1_obs1", 32'(xfer_obs[x0+1]), 32'h10);
        chk("t1_blk1", 32'(xfer_blk[x0+1]), 1);
        chk("t1_idx2", 32'(xfer_idx[x0+2]), 7);
        chk("t1_obs2", 32'(xfer_obs[x0+2]), 0);
        chk("t1_done_n", 32'(done_n - d0), 1);
        chk("t1_done_at", 32'(done_cyc - xfer_cyc[x0+2]), 1);
`ifdef PRM_EDGE_CHK_STATS_EN
        chk("t1_blocked_cnt", 32'(blocked_cnt), 1);
`endif

        // zero-length sweep
        d0 = done_n; b0 = busy_n; q0 = req_n; v0 = vld_n;
        go(9, 0);
        @(negedge clk);
        chk("t2_done_next", 32'(done), 1);
        chk("t2_busy_next", 32'(busy), 1);
        cyc(4);
        chk("t2_busy_cycles", 32'(busy_n - b0), 1);
        chk("t2_done_n", 32'(done_n - d0), 1);
        chk("t2_no_req", 32'(req_n - q0), 0);
        chk("t2_no_vld", 32'(vld_n - v0), 0);

        // index wrap
        x0 = xfer_idx.size(); r0 = req_addr.size();
        go(1022, 3);
        wait_done("t3_timeout");
        cyc(2);
        chk("t3_addr0", 32'(req_addr[r0]), 1022);
        chk("t3_addr1", 32'(req_addr[r0+1]), 1023);
        chk("t3_addr2", 32'(req_addr[r0+2]), 0);
        chk("t3_idx0", 32'(xfer_idx[x0]), 1022);
        chk("t3_idx1", 32'(xfer_idx[x0+1]), 1023);
        chk("t3_idx2", 32'(xfer_idx[x0+2]), 0);

        // backpressure in EMIT
        res_rdy = 0;
        x0 = xfer_idx.size(); r0 = req_addr.size(); q0 = req_n;
        go(20, 2);
        n = 0;
        @(negedge clk);
        while (!res_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_vld_timeout", 32'(n < 100), 1);
        i0 = res_idx; o0 = res_obs;
        toggle_mask = 1;
        moved = 0;
        repeat (5) begin
            @(negedge clk);
            if (res_idx != i0 || res_obs != o0 || !res_vld || code_req) moved = 1;
        end
        chk("t4_stable", 32'(moved), 0);
        chk("t4_idx", 32'(i0), 20);
        chk("t4_obs", 32'(o0), 32'h81);
        @(posedge clk); #1;
        res_rdy = 1;
        toggle_mask = 0;
        wait_done("t4_timeout");
        cyc(2);
        chk("t4_count", 32'(xfer_idx.size() - x0), 2);
        chk("t4_x_obs0", 32'(xfer_obs[x0]), 32'h81);
        chk("t4_x_idx1", 32'(xfer_idx[x0+1]), 21);
        chk("t4_x_obs1", 32'(xfer_obs[x0+1]), 32'h02);
        chk("t4_req_after", 32'(req_cyc[r0+1] > xfer_cyc[x0]), 1);

        // abort during CHECK of second edge
        x0 = xfer_idx.size(); d0 = done_n;
        go(40, 4);
        n = 0;
        @(negedge clk);
        while (!(xfer_idx.size() == x0 + 1 && busy && !code_req && !res_vld) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_check_timeout", 32'(n < 100), 1);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_vld", 32'(res_vld), 0);
        chk("t5_req", 32'(code_req), 0);
        cc = chk_code; v0 = vld_n;
        force_vld = 1;
        cyc(1);
        force_vld = 0;
        cyc(10);
        chk("t5_late_vld", 32'(chk_code), 32'(cc));
        chk("t5_no_vld", 32'(vld_n - v0), 0);
        chk("t5_no_done", 32'(done_n - d0), 0);
        chk("t5_count", 32'(xfer_idx.size() - x0), 1);
        go(60, 1);
        wait_done("t5_restart_timeout");
        cyc(1);
        chk("t5_restart_idx", 32'(xfer_idx[xfer_idx.size()-1]), 60);

        // start while busy is ignored
        x0 = xfer_idx.size();
        go(100, 2);
        cyc(3);
        go(500, 5);
        wait_done("t6_timeout");
        cyc(4);
        chk("t6_count", 32'(xfer_idx.size() - x0), 2);
        chk("t6_idx0", 32'(xfer_idx[x0]), 100);
        chk("t6_obs0", 32'(xfer_obs[x0]), 32'h40);
        chk("t6_idx1", 32'(xfer_idx[x0+1]), 101);
        chk("t6_obs1", 32'(xfer_obs[x0+1]), 32'h07);
        chk("t6_idle", 32'(busy), 0);
        chk("t6_code_kept", 32'(chk_code), 32'(code_of(10'd101)));
`ifdef PRM_EDGE_CHK_STATS_EN
        chk("t6_blocked_cnt", 32'(blocked_cnt), 2);
`endif

        // reset mid-sweep
        d0 = done_n;
        go(200, 3);
        cyc(5);
        rst_n = 0;
        cyc(1);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_req", 32'(code_req), 0);
        chk("t7_vld", 32'(res_vld), 0);
        rst_n = 1;
        cyc(5);
        chk("t7_no_done", 32'(done_n - d0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
